dp_iso_rx_depacker: RTL
=======================

# dp_iso_rx_depacker

Sink-side isochronous-stream depacker for the DisplayPort link path. It consumes the per-lane ISO symbols and control-symbol flags that the source-side packer produces (up to 4 lanes, 8 bits each) and recovers the line framing: blanking start, VB-ID, active-video start and fill regions. It delivers the active-video bytes as a registered, byte-enabled stream to the pixel reconstruction stage. Framing and alignment faults are flagged and the block resynchronises on the next blanking start.

## Interface
- AUX_DATA_WIDTH, 8, symbol width per lane (only 8 supported)
- clk  input  1  link symbol clock
- rst  input  1  asynchronous, active-high reset
- iso_symbols_lane0..lane3  input  AUX_DATA_WIDTH each  received symbols, lane n
- control_sym_flag_lane0..lane3  input  1 each  1 = symbol on lane n is a control symbol
- iso_valid  input  1  symbol beat valid on all lanes
- lane_count  input  2  2'b00 = 1 lane, 2'b01 = 2 lanes, 2'b11 = 4 lanes; 2'b10 is treated as 4 lanes
- pixel_data  output  4*AUX_DATA_WIDTH  {lane3,lane2,lane1,lane0} active-video bytes
- pixel_byte_en  output  4  byte enables for pixel_data
- pixel_valid  output  1  pixel_data/pixel_byte_en valid
- hsync_start  output  1  one-cycle pulse on accepted BS/SR
- active_start  output  1  one-cycle pulse on accepted BE
- vblank_flag  output  1  VB-ID bit0 of the current line
- align_err  output  1  one-cycle pulse: lanes disagree
- ctrl_err  output  1  one-cycle pulse: illegal or unexpected control symbol
- line_sym_count  output  16  active data beats of previous line (only with macro)

## Operation
- Active lanes: lanes 0..N-1 per lane_count. lane_count is sampled only in IDLE and when a BS/SR is accepted. It is held otherwise.
- Control codes (flag = 1): BS = 8'hBC, SR = 8'h1C (treated as BS), BE = 8'hFB, FS = 8'hFE, FE = 8'hF7. Any other value with flag = 1 is illegal and raises ctrl_err.
- Beat classification, on iso_valid = 1 only:
  - Control beat: all active flags = 1 and all active symbols equal.
  - Data beat: all active flags = 0.
  - Any other mix raises align_err, the FSM goes to IDLE and no output is produced.
- FSM states: IDLE, BLANK_VBID, BLANK, ACTIVE, FILL.
  - BS/SR from any state: hsync_start, go to BLANK_VBID.
  - IDLE: every other beat is ignored and raises no error.
  - BLANK_VBID: the next data beat latches vblank_flag = lane0[0], go to BLANK.
  - BLANK: data is ignored. BE: active_start, go to ACTIVE.
  - ACTIVE: a data beat drives pixel_valid = 1, with pixel_data = active lane bytes and inactive bytes = 0. pixel_byte_en = 4'b0001 / 4'b0011 / 4'b1111 by lane_count. FS: go to FILL.
  - FILL: data is discarded. FE: go to ACTIVE.
- Unexpected legal control (BE outside BLANK, FS outside ACTIVE, FE outside FILL, any control in BLANK_VBID other than BS/SR): ctrl_err, go to IDLE.
- iso_valid = 0: no state change and all pulses are 0. pixel_valid = 0 and pixel_data holds its last value.

## Timing
- All outputs are registered: 1-cycle latency from input beat to output.
- Reset values: all outputs 0, FSM = IDLE, line counter 0. Reset asserted mid-line aborts the line. The output after release starts from IDLE, with no pixel_valid until BS followed by BE.
- A BS arriving in the same beat as an error condition cannot occur, because BS is itself a control beat. A misaligned BS beat is an align_err, not a BS.
- Pulses are exactly one cycle per qualifying beat, and back-to-back beats produce back-to-back pulses.

## Configuration
- DP_RX_LINE_SYM_COUNT_EN defined:
  - A 16-bit counter increments on each ACTIVE data beat and saturates at 16'hFFFF.
  - On accepted BS/SR, line_sym_count is registered from the counter and the counter clears.
  - ctrl_err and align_err also clear the counter.
  - line_sym_count resets to 0.
- Macro undefined: the line_sym_count port and the counter are absent.

## Test plan
- 4 lanes, beats BS → data 8'h01 (VB-ID) → BE → 3 data beats 32'h44332211 → vblank_flag = 1, active_start pulse, 3 pixel_valid cycles with pixel_byte_en = 4'b1111 and pixel_data = 32'h44332211.
- 2 lanes, BS, VB-ID 8'h00, BE, data lanes {0xBB,0xAA} → pixel_data = 32'h0000BBAA, pixel_byte_en = 4'b0011, vblank_flag = 0.
- ACTIVE with FS, 2 data beats, FE, 1 data beat → exactly 1 pixel_valid after FE and none during fill.
- 4 lanes, flags 4'b0111 with 8'hBC on lanes 0-2 → align_err pulse, FSM to IDLE; later data beats produce no pixel_valid until BS, BE.
- Control 8'h55 in ACTIVE → ctrl_err; a subsequent BE without BS → ignored (IDLE), no active_start.
- Macro on: line of 5 data beats then BS → line_sym_count = 5; rst asserted mid-line → all outputs 0 immediately.

Source files
------------

// File: rtl/dp_iso_rx_depacker.sv
// dp_iso_rx_depacker
// Sink-side isochronous-stream depacker. Classifies each symbol beat across
// the active lanes as control, data or misaligned, tracks the line framing
// (BS/SR -> VB-ID -> BE -> active video, with FS/FE fill regions) and emits
// the active-video bytes as a registered, byte-enabled stream.
//
// Ports:
//   clk, rst                        symbol clock, async active-high reset
//   iso_symbols_lane0..3            received symbols per lane
//   control_sym_flag_lane0..3       1 = symbol on that lane is a control symbol
//   iso_valid                       beat valid on all lanes
//   lane_count                      00=1 lane, 01=2 lanes, 1x=4 lanes
//   pixel_data/pixel_byte_en        {lane3..lane0} active-video bytes + enables
//   pixel_valid                     pixel_data/pixel_byte_en valid
//   hsync_start, active_start       one-cycle pulses on accepted BS/SR and BE
//   vblank_flag                     VB-ID bit0 of the current line
//   align_err, ctrl_err             one-cycle fault pulses
//   line_sym_count                  active data beats of the previous line
//                                   (present only with DP_RX_LINE_SYM_COUNT_EN)
module dp_iso_rx_depacker #(
  parameter int AUX_DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AUX_DATA_WIDTH-1:0]   iso_symbols_lane0,
  input  logic [AUX_DATA_WIDTH-1:0]   iso_symbols_lane1,
  input  logic [AUX_DATA_WIDTH-1:0]   iso_symbols_lane2,
  input  logic [AUX_DATA_WIDTH-1:0]   iso_symbols_lane3,
  input  logic                        control_sym_flag_lane0,
  input  logic                        control_sym_flag_lane1,
  input  logic                        control_sym_flag_lane2,
  input  logic                        control_sym_flag_lane3,
  input  logic                        iso_valid,
  input  logic [1:0]                  lane_count,
  output logic [4*AUX_DATA_WIDTH-1:0] pixel_data,
  output logic [3:0]                  pixel_byte_en,
  output logic                        pixel_valid,
  output logic                        hsync_start,
  output logic                        active_start,
  output logic                        vblank_flag,
  output logic                        align_err,
  output logic                        ctrl_err
`ifdef DP_RX_LINE_SYM_COUNT_EN
  ,
  output logic [15:0]                 line_sym_count
`endif
);

  localparam int W = AUX_DATA_WIDTH;
  localparam logic [W-1:0] K_BS = 8'hBC;
  localparam logic [W-1:0] K_SR = 8'h1C;
  localparam logic [W-1:0] K_BE = 8'hFB;
  localparam logic [W-1:0] K_FS = 8'hFE;
  localparam logic [W-1:0] K_FE = 8'hF7;

  typedef enum logic [2:0] {IDLE, BLANK_VBID, BLANK, ACTIVE, FILL} state_t;

  state_t         state_q, state_d;
  logic [1:0]     lc_q;
  logic [1:0]     eff_lc;
  logic [3:0]     mask;
  logic [3:0]     flg;
  logic [W-1:0]   sym [4];
  logic           sym_eq, ctrl_beat, data_beat;
  logic           is_bs, is_be, is_fs, is_fe;
  logic           hs_d, as_d, ae_d, ce_d, pv_d, vb_ld, bs_acc;
  logic [4*W-1:0] pix_d;

  assign sym[0] = iso_symbols_lane0;
  assign sym[1] = iso_symbols_lane1;
  assign sym[2] = iso_symbols_lane2;
  assign sym[3] = iso_symbols_lane3;
  assign flg    = {control_sym_flag_lane3, control_sym_flag_lane2,
                   control_sym_flag_lane1, control_sym_flag_lane0};

  // In IDLE the lane configuration follows the input live; elsewhere the
  // value captured at the last accepted BS/SR governs classification.
  assign eff_lc = (state_q == IDLE) ? lane_count : lc_q;

  always_comb begin
    case (eff_lc)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

  always_comb begin
    sym_eq = 1'b1;
    for (int i = 1; i < 4; i++) begin
      if (mask[i] && (sym[i] != sym[0])) sym_eq = 1'b0;
    end
  end

  assign ctrl_beat = ((flg & mask) == mask) && sym_eq;
  assign data_beat = ((flg & mask) == 4'b0000);
  assign is_bs     = (sym[0] == K_BS) || (sym[0] == K_SR);
  assign is_be     = (sym[0] == K_BE);
  assign is_fs     = (sym[0] == K_FS);
  assign is_fe     = (sym[0] == K_FE);

  assign pix_d = {mask[3] ? sym[3] : {W{1'b0}},
                  mask[2] ? sym[2] : {W{1'b0}},
                  mask[1] ? sym[1] : {W{1'b0}},
                  sym[0]};

  always_comb begin
    state_d = state_q;
    hs_d    = 1'b0;
    as_d    = 1'b0;
    ae_d    = 1'b0;
    ce_d    = 1'b0;
    pv_d    = 1'b0;
    vb_ld   = 1'b0;
    bs_acc  = 1'b0;
    if (iso_valid) begin
      if (!ctrl_beat && !data_beat) begin
        ae_d    = 1'b1;
        state_d = IDLE;
      end else if (ctrl_beat && is_bs) begin
        hs_d    = 1'b1;
        bs_acc  = 1'b1;
        state_d = BLANK_VBID;
      end else begin
        // Any control beat not matching the one transition allowed in the
        // current state (including illegal codes) is a framing fault.
        case (state_q)
          IDLE: ;
          BLANK_VBID: begin
            if (data_beat) begin
              vb_ld   = 1'b1;
              state_d = BLANK;
            end else begin
              ce_d    = 1'b1;
              state_d = IDLE;
            end
          end
          BLANK: begin
            if (ctrl_beat) begin
              if (is_be) begin
                as_d    = 1'b1;
                state_d = ACTIVE;
              end else begin
                ce_d    = 1'b1;
                state_d = IDLE;
              end
            end
          end
          ACTIVE: begin
            if (data_beat) begin
              pv_d = 1'b1;
            end else if (is_fs) begin
              state_d = FILL;
            end else begin
              ce_d    = 1'b1;
              state_d = IDLE;
            end
          end
          FILL: begin
            if (ctrl_beat) begin
              if (is_fe) begin
                state_d = ACTIVE;
              end else begin
                ce_d    = 1'b1;
                state_d = IDLE;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lc_q          <= 2'b00;
      pixel_data    <= '0;
      pixel_byte_en <= 4'b0000;
      pixel_valid   <= 1'b0;
      hsync_start   <= 1'b0;
      active_start  <= 1'b0;
      vblank_flag   <= 1'b0;
      align_err     <= 1'b0;
      ctrl_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pixel_valid  <= pv_d;
      hsync_start  <= hs_d;
      active_start <= as_d;
      align_err    <= ae_d;
      ctrl_err     <= ce_d;
      if ((state_q == IDLE) || bs_acc) lc_q <= lane_count;
      if (vb_ld) vblank_flag <= sym[0][0];
      if (pv_d) begin
        pixel_data    <= pix_d;
        pixel_byte_en <= mask;
      end
    end
  end

`ifdef DP_RX_LINE_SYM_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= 16'h0000;
      line_sym_count <= 16'h0000;
    end else if (ae_d || ce_d) begin
      cnt_q <= 16'h0000;
    end else if (bs_acc) begin
      line_sym_count <= cnt_q;
      cnt_q          <= 16'h0000;
    end else if (pv_d && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'h0001;
    end
  end
`endif

endmodule
